// File: rtl/display_pkg.sv
// Shared display encodings: cursor styles, blink states and default RGB444 colours.
// Also a small helper that sizes the blink frame counter.
package display_pkg;

   typedef enum logic [1:0] {
      MODE_BLOCK     = 2'd0,
      MODE_INVERSE   = 2'd1,
      MODE_UNDERLINE = 2'd2,
      MODE_STEADY    = 2'd3
   } cursor_mode_e;

   typedef enum logic {
      CUR_ON  = 1'b0,
      CUR_OFF = 1'b1
   } blink_state_e;

   localparam logic [11:0] DEF_GRID_ON  = 12'hccc;
   localparam logic [11:0] DEF_GRID_OFF = 12'h333;
   localparam logic [11:0] DEF_TEXT_FG  = 12'hfff;
   localparam logic [11:0] DEF_TEXT_BG  = 12'h000;

   // A single-frame half-period still needs a 1-bit counter.
   function automatic int cnt_width(input int frames);
      return (frames > 1) ? $clog2(frames) : 1;
   endfunction

endpackage

// File: rtl/cursor_blink.sv
// Frame-counted cursor blink FSM. cur_on is the FSM state itself (1 while CUR_ON),
// so it doubles as the observable state of this block.
module cursor_blink
   import display_pkg::*;
#(
   parameter int CUR_W        = 5,
   parameter int BLINK_FRAMES = 30
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [9:0]       h_cnt,
   input  logic [9:0]       v_cnt,
   input  logic             editing,
   input  logic [CUR_W-1:0] writing_x,
   input  logic [CUR_W-1:0] writing_y,
   output logic             cur_on
);

   localparam int CNT_W = cnt_width(BLINK_FRAMES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   blink_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CUR_W-1:0] prev_x_q, prev_y_q;
   logic             tick;
   logic             restart;

   assign tick    = valid && (h_cnt == 10'd0) && (v_cnt == 10'd0);
   assign restart = !editing || (writing_x != prev_x_q) || (writing_y != prev_y_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= CUR_ON;
         cnt_q    <= '0;
         prev_x_q <= '0;
         prev_y_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prev_x_q <= writing_x;
         prev_y_q <= writing_y;
      end
   end

   // A restart wins over a frame tick landing in the same cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (restart) begin
         state_d = CUR_ON;
         cnt_d   = '0;
      end else if (tick) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (state_q)
               CUR_ON:  state_d = CUR_OFF;
               CUR_OFF: state_d = CUR_ON;
               default: state_d = CUR_ON;
            endcase
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign cur_on = (state_q == CUR_ON);

endmodule

// File: rtl/grid_pixel_gen.sv
// Registered text-grid pixel generator: mouse overlay, grid lines, blinking cursor and glyphs.
// Two register stages: S1 captures inputs and derived flags, S2 registers the priority mux.
module grid_pixel_gen
   import display_pkg::*;
#(
   parameter int                 CELL_LOG2    = 5,
   parameter int                 COLOR_W      = 12,
   parameter logic [COLOR_W-1:0] GRID_ON      = COLOR_W'(DEF_GRID_ON),
   parameter logic [COLOR_W-1:0] GRID_OFF     = COLOR_W'(DEF_GRID_OFF),
   parameter logic [COLOR_W-1:0] TEXT_FG      = COLOR_W'(DEF_TEXT_FG),
   parameter logic [COLOR_W-1:0] TEXT_BG      = COLOR_W'(DEF_TEXT_BG),
   parameter int                 BLINK_FRAMES = 30,
   parameter int                 CUR_W        = 10 - CELL_LOG2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid,
   input  logic [9:0]         h_cnt,
   input  logic [9:0]         v_cnt,
   input  logic               enable_mouse_display,
   input  logic [COLOR_W-1:0] mouse_pixel,
   input  logic               enable_word_display,
   input  logic               word_pixel,
   input  logic               mem_pixel,
   input  logic               editing,
   input  logic [CUR_W-1:0]   writing_x,
   input  logic [CUR_W-1:0]   writing_y,
   input  logic [1:0]         cursor_mode,
   output logic [COLOR_W-1:0] pixel,
   output logic               pixel_valid
);

   localparam logic [CELL_LOG2-1:0] LO_MAX = {CELL_LOG2{1'b1}};

   logic                 cur_on;
   logic [CELL_LOG2-1:0] h_lo, v_lo;
   logic                 border_d, in_cur_d, ul_row_d;

   logic                 valid_s1, mouse_en_s1, mem_s1, word_s1, wen_s1;
   logic                 border_s1, in_cur_s1, ul_row_s1, cur_on_s1;
   logic [COLOR_W-1:0]   mouse_px_s1;
   logic [1:0]           mode_s1;

   logic                 cur_vis;
   logic [COLOR_W-1:0]   pix_d;

   cursor_blink #(
      .CUR_W       (CUR_W),
      .BLINK_FRAMES(BLINK_FRAMES)
   ) u_blink (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (valid),
      .h_cnt    (h_cnt),
      .v_cnt    (v_cnt),
      .editing  (editing),
      .writing_x(writing_x),
      .writing_y(writing_y),
      .cur_on   (cur_on)
   );

   assign h_lo = h_cnt[CELL_LOG2-1:0];
   assign v_lo = v_cnt[CELL_LOG2-1:0];

   assign border_d = (h_lo == '0) || (h_lo == LO_MAX) || (v_lo == '0) || (v_lo == LO_MAX);
   assign in_cur_d = editing && (h_cnt[9:CELL_LOG2] == writing_x) && (v_cnt[9:CELL_LOG2] == writing_y);
   // Underline occupies the two rows just above the bottom grid line.
   assign ul_row_d = (v_lo == LO_MAX - CELL_LOG2'(1)) || (v_lo == LO_MAX - CELL_LOG2'(2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_s1    <= 1'b0;
         mouse_en_s1 <= 1'b0;
         mouse_px_s1 <= '0;
         mem_s1      <= 1'b0;
         word_s1     <= 1'b0;
         wen_s1      <= 1'b0;
         mode_s1     <= 2'd0;
         border_s1   <= 1'b0;
         in_cur_s1   <= 1'b0;
         ul_row_s1   <= 1'b0;
         cur_on_s1   <= 1'b0;
      end else begin
         valid_s1    <= valid;
         mouse_en_s1 <= enable_mouse_display;
         mouse_px_s1 <= mouse_pixel;
         mem_s1      <= mem_pixel;
         word_s1     <= word_pixel;
         wen_s1      <= enable_word_display;
         mode_s1     <= cursor_mode;
         border_s1   <= border_d;
         in_cur_s1   <= in_cur_d;
         ul_row_s1   <= ul_row_d;
         cur_on_s1   <= cur_on;
      end
   end

   assign cur_vis = cur_on_s1 || (cursor_mode_e'(mode_s1) == MODE_STEADY);

   // A hidden cursor cell drops through to the text / blank rules.
   always_comb begin
      pix_d = TEXT_BG;
      if (!valid_s1) begin
         pix_d = '0;
      end else if (mouse_en_s1) begin
         pix_d = mouse_px_s1;
      end else if (border_s1) begin
         pix_d = mem_s1 ? GRID_ON : GRID_OFF;
      end else if (in_cur_s1 && cur_vis) begin
         case (cursor_mode_e'(mode_s1))
            MODE_BLOCK, MODE_STEADY: pix_d = mem_s1 ? TEXT_FG : TEXT_BG;
            MODE_INVERSE:            pix_d = mem_s1 ? TEXT_BG : TEXT_FG;
            MODE_UNDERLINE: begin
               if (ul_row_s1)                pix_d = TEXT_FG;
               else if (wen_s1 && word_s1)   pix_d = TEXT_FG;
               else                          pix_d = TEXT_BG;
            end
            default:                 pix_d = TEXT_BG;
         endcase
      end else if (wen_s1) begin
         pix_d = word_s1 ? TEXT_FG : TEXT_BG;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel       <= '0;
         pixel_valid <= 1'b0;
      end else begin
         pixel       <= pix_d;
         pixel_valid <= valid_s1;
      end
   end

endmodule

// File: tb/tb_grid_pixel_gen.sv
// Bench for grid_pixel_gen: directed scenarios plus a random stream, checked through
// an expected queue that is compared two clocks after each stimulus cycle.
module tb_grid_pixel_gen;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic        enable_mouse_display = 1'b0;
  logic [11:0] mouse_pixel = '0;
  logic        enable_word_display = 1'b0;
  logic        word_pixel = 1'b0;
  logic        mem_pixel = 1'b0;
  logic        editing = 1'b0;
  logic [4:0]  writing_x = '0;
  logic [4:0]  writing_y = '0;
  logic [1:0]  cursor_mode = '0;
  logic [11:0] pixel;
  logic        pixel_valid;

  always #5 clk = ~clk;

  grid_pixel_gen #(.BLINK_FRAMES(BF)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .valid               (valid),
    .h_cnt               (h_cnt),
    .v_cnt               (v_cnt),
    .enable_mouse_display(enable_mouse_display),
    .mouse_pixel         (mouse_pixel),
    .enable_word_display (enable_word_display),
    .word_pixel          (word_pixel),
    .mem_pixel           (mem_pixel),
    .editing             (editing),
    .writing_x           (writing_x),
    .writing_y           (writing_y),
    .cursor_mode         (cursor_mode),
    .pixel               (pixel),
    .pixel_valid         (pixel_valid)
  );

  // scoreboard: entries are {pixel_valid, pixel}
  logic [12:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          sb_en = 1'b0;
  logic [12:0] sb_exp;
  string       sb_name;

  // golden blink model
  bit          m_off;
  int          m_cnt;
  logic [4:0]  m_px, m_py;

  always @(posedge clk) begin
    #1;
    if (sb_en && exp_q.size() >= 2) begin
      sb_exp  = exp_q.pop_front();
      sb_name = name_q.pop_front();
      checks++;
      if ({pixel_valid, pixel} !== sb_exp) begin
        errors++;
        $display("FAIL %s: got valid=%0b pixel=%h, expected valid=%0b pixel=%h",
                 sb_name, pixel_valid, pixel, sb_exp[12], sb_exp[11:0]);
      end
    end
  end

  function automatic logic [12:0] model_out();
    int hl, vl;
    bit border, in_cur, ul, vis;
    logic [11:0] p;
    if (!valid) return 13'h0;
    hl = int'(h_cnt) % 32;
    vl = int'(v_cnt) % 32;
    border = (hl == 0) || (hl == 31) || (vl == 0) || (vl == 31);
    in_cur = editing && (int'(h_cnt) / 32 == int'(writing_x)) && (int'(v_cnt) / 32 == int'(writing_y));
    ul = (vl == 30) || (vl == 29);
    vis = !m_off || (cursor_mode == 2'd3);
    if (enable_mouse_display) p = mouse_pixel;
    else if (border) p = mem_pixel ? 12'hccc : 12'h333;
    else if (in_cur && vis) begin
      if (cursor_mode == 2'd1) p = mem_pixel ? 12'h000 : 12'hfff;
      else if (cursor_mode == 2'd2) p = (ul || (enable_word_display && word_pixel)) ? 12'hfff : 12'h000;
      else p = mem_pixel ? 12'hfff : 12'h000;
    end
    else if (enable_word_display) p = word_pixel ? 12'hfff : 12'h000;
    else p = 12'h000;
    return {1'b1, p};
  endfunction

  task automatic model_update();
    bit restart, tick;
    restart = !editing || (writing_x != m_px) || (writing_y != m_py);
    tick = valid && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    if (restart) begin
      m_off = 1'b0;
      m_cnt = 0;
    end else if (tick) begin
      if (m_cnt == BF - 1) begin
        m_cnt = 0;
        m_off = !m_off;
      end else begin
        m_cnt++;
      end
    end
    m_px = writing_x;
    m_py = writing_y;
  endtask

  // one stimulus cycle: inputs already set at the negedge
  task automatic step(input logic [12:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    valid = 1'b0; h_cnt = '0; v_cnt = '0;
    enable_mouse_display = 1'b0; mouse_pixel = '0;
    enable_word_display = 1'b0; word_pixel = 1'b0; mem_pixel = 1'b0;
    editing = 1'b0; writing_x = '0; writing_y = '0; cursor_mode = 2'd0;
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pixel !== 12'h000) begin
      errors++;
      $display("FAIL reset_pixel: got %h, expected 000", pixel);
    end
    checks++;
    if (pixel_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %0b, expected 0", pixel_valid);
    end
    repeat (2) @(negedge clk);
    exp_q.delete();
    name_q.delete();
    m_off = 1'b0; m_cnt = 0; m_px = '0; m_py = '0;
    rst_n = 1'b1;
    exp_q.push_back(13'h0);
    name_q.push_back("post_reset_pipe");
    sb_en = 1'b1;
  endtask

  task automatic cur_px(input logic [12:0] e, input string nm);
    valid = 1'b1; h_cnt = 10'd70; v_cnt = 10'd40; mem_pixel = 1'b1;
    step(e, nm);
  endtask

  task automatic tick(input string nm);
    valid = 1'b1; h_cnt = 10'd0; v_cnt = 10'd0; mem_pixel = 1'b0;
    step(13'h1333, nm);
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle();
    do_reset();
    valid = 1'b1; h_cnt = 10'd40; v_cnt = 10'd40; enable_word_display = 1'b1; word_pixel = 1'b1;
    step(13'h1fff, "first_after_reset");
    h_cnt = 10'd41;
    step(13'h1fff, "mid_line_a");
    h_cnt = 10'd42;
    step(13'h1fff, "mid_line_b");
    do_reset();
    step(13'h1fff, "first_after_mid_reset");
    set_idle();
  endtask

  task automatic test_grid();
    valid = 1'b1; h_cnt = 10'd32; v_cnt = 10'd40; mem_pixel = 1'b1;
    step(13'h1ccc, "grid_on_left");
    h_cnt = 10'd63; mem_pixel = 1'b0;
    step(13'h1333, "grid_off_right");
    h_cnt = 10'd40; v_cnt = 10'd31; mem_pixel = 1'b1;
    step(13'h1ccc, "grid_on_bottom");
    h_cnt = 10'd32; enable_mouse_display = 1'b1; mouse_pixel = 12'h0f0;
    step(13'h10f0, "mouse_over_border");
    enable_mouse_display = 1'b0; h_cnt = 10'd40; v_cnt = 10'd40;
    enable_word_display = 1'b1; word_pixel = 1'b1;
    step(13'h1fff, "glyph_fg");
    word_pixel = 1'b0;
    step(13'h1000, "glyph_bg");
    enable_word_display = 1'b0;
    step(13'h1000, "blank");
    set_idle();
  endtask

  task automatic test_cursor();
    writing_x = 5'd2; writing_y = 5'd1; enable_word_display = 1'b1; word_pixel = 1'b0;
    editing = 1'b0;
    cur_px(13'h1000, "no_edit_no_cursor");
    editing = 1'b1; cursor_mode = 2'd0;
    cur_px(13'h1fff, "block_cursor");
    cursor_mode = 2'd1;
    cur_px(13'h1000, "inverse_cursor");
    cursor_mode = 2'd2; v_cnt = 10'd61; valid = 1'b1; h_cnt = 10'd70;
    step(13'h1fff, "underline_row");
    v_cnt = 10'd40;
    step(13'h1000, "underline_off_row");
    word_pixel = 1'b1;
    step(13'h1fff, "underline_glyph");
    set_idle();
  endtask

  task automatic test_blink();
    writing_x = 5'd2; writing_y = 5'd1; enable_word_display = 1'b1; word_pixel = 1'b0;
    cursor_mode = 2'd0; editing = 1'b0;
    cur_px(13'h1000, "blink_restart");
    editing = 1'b1;
    cur_px(13'h1fff, "blink_f0_on");
    tick("tick1");
    cur_px(13'h1fff, "blink_f1_on");
    tick("tick2");
    cur_px(13'h1000, "blink_f2_off");
    tick("tick3");
    cur_px(13'h1000, "blink_f3_off");
    tick("tick4");
    cur_px(13'h1fff, "blink_f4_on");
    tick("tick5");
    tick("tick6");
    cursor_mode = 2'd3;
    cur_px(13'h1fff, "steady_while_off");
    tick("tick7");
    tick("tick8");
    cur_px(13'h1fff, "steady_while_on");
    set_idle();
  endtask

  task automatic test_restart();
    writing_x = 5'd2; writing_y = 5'd1; enable_word_display = 1'b1; word_pixel = 1'b0;
    cursor_mode = 2'd0; editing = 1'b0;
    cur_px(13'h1000, "rs_restart");
    editing = 1'b1;
    tick("rs_tick1");
    tick("rs_tick2");
    cur_px(13'h1000, "rs_hidden");
    writing_x = 5'd3; valid = 1'b1; h_cnt = 10'd102; v_cnt = 10'd40; mem_pixel = 1'b1;
    step(13'h1000, "move_same_cycle");
    step(13'h1fff, "move_next_cycle_on");
    tick("rs_tick3");
    valid = 1'b1; h_cnt = 10'd102; v_cnt = 10'd40; mem_pixel = 1'b1;
    step(13'h1fff, "counter_restarted");
    tick("rs_tick4");
    valid = 1'b1; h_cnt = 10'd102; v_cnt = 10'd40; mem_pixel = 1'b1;
    step(13'h1000, "off_after_two");
    cursor_mode = 2'd1; word_pixel = 1'b1; editing = 1'b0;
    step(13'h1fff, "edit_dropped");
    editing = 1'b1;
    step(13'h1000, "edit_back_on");
    set_idle();
  endtask

  task automatic test_valid();
    enable_mouse_display = 1'b1; mouse_pixel = 12'h0f0; h_cnt = 10'd32; v_cnt = 10'd40;
    valid = 1'b0;
    step(13'h0000, "invalid_mouse");
    enable_mouse_display = 1'b0; mem_pixel = 1'b1;
    step(13'h0000, "invalid_border");
    set_idle();
  endtask

  task automatic test_back_to_back();
    writing_x = 5'd2; writing_y = 5'd1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        h_cnt = 10'd0; v_cnt = 10'd0;
      end else begin
        h_cnt = 10'($urandom_range(0, 127));
        v_cnt = 10'($urandom_range(0, 63));
      end
      valid = ($urandom_range(0, 7) != 0);
      enable_mouse_display = ($urandom_range(0, 7) == 0);
      mouse_pixel = 12'($urandom_range(0, 4095));
      enable_word_display = $urandom_range(0, 1);
      word_pixel = $urandom_range(0, 1);
      mem_pixel = $urandom_range(0, 1);
      editing = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) writing_x = 5'($urandom_range(0, 3));
      cursor_mode = 2'($urandom_range(0, 3));
      step(model_out(), "random_stream");
    end
    set_idle();
    step(13'h0, "drain0");
    step(13'h0, "drain1");
    step(13'h0, "drain2");
  endtask

  initial begin
    test_reset();
    test_grid();
    test_cursor();
    test_blink();
    test_restart();
    test_valid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
